// File: rtl/kpd_pkg.sv
// Keypad encoder shared types.
// FSM state encoding and the counter width helper.
package kpd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } kpd_state_t;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/kpd_prio_enc.sv
// Combinational priority encoder: highest asserted key wins.
// Also flags any key and more than one key.
module kpd_prio_enc #(
    parameter int NUM_KEYS = 10,
    parameter int CODE_W   = 4
) (
    input  logic [NUM_KEYS-1:0] keys,
    output logic [CODE_W-1:0]   code,
    output logic                any,
    output logic                multi
);

    always_comb begin
        code = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) code = CODE_W'(i);
        end
    end

    assign any   = |keys;
    // clearing the lowest set bit leaves something only if 2+ keys are set
    assign multi = |(keys & (keys - NUM_KEYS'(1)));

endmodule

// File: rtl/keypad_encoder_db.sv
// Debounced keypad encoder with valid/ready output,
// optional auto-repeat and a free-running 1 Hz tick.
module keypad_encoder_db
    import kpd_pkg::*;
#(
    parameter int NUM_KEYS        = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 7,
    parameter int TICK_DIV        = 50000000,
    parameter int REPEAT_TICKS    = 0
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                enable,
    output logic [CODE_W-1:0]   code,
    output logic                code_valid,
    input  logic                code_ready,
    output logic                loadn,
    output logic                multi_key,
    output logic                tick_1hz
);

    localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
    localparam int RPT_W = cnt_w(REPEAT_TICKS + 1);
    localparam int TCK_W = cnt_w(TICK_DIV);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS);
    localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(TICK_DIV - 1);

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [CODE_W-1:0]   enc;
    logic                any_key, multi;

    kpd_state_t        state_q, state_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic              valid_q, valid_d;
    logic              multi_q;
    logic [TCK_W-1:0]  tck_q;
    logic              tick;

    kpd_prio_enc #(
        .NUM_KEYS (NUM_KEYS),
        .CODE_W   (CODE_W)
    ) u_enc (
        .keys  (sync2_q),
        .code  (enc),
        .any   (any_key),
        .multi (multi)
    );

    assign tick = (tck_q == TCK_LAST);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= IDLE;
            cand_q  <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            rpt_q   <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            tck_q   <= '0;
        end else begin
            sync1_q <= keypad;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            valid_q <= valid_d;
            multi_q <= multi;
            tck_q   <= tick ? '0 : tck_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        valid_d = valid_q;
        if (valid_q && code_ready) valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_key && enable && !valid_q) begin
                    cand_d  = enc;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (any_key && enc == cand_q) begin
                    if (cnt_q == DB_LAST) begin
                        code_d  = cand_q;
                        valid_d = 1'b1;
                        rpt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (!any_key) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else if (REPEAT_TICKS > 0 && enc == code_q) begin
                    // a re-issue waits until the previous code has left
                    if (rpt_q == RPT_LAST && !valid_q) begin
                        valid_d = 1'b1;
                        rpt_d   = '0;
                    end else if (tick && rpt_q != RPT_LAST) begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (any_key) begin
                    state_d = HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    assign code       = code_q;
    assign code_valid = valid_q;
    assign loadn      = ~(valid_q & code_ready);
    assign multi_key  = multi_q;
    assign tick_1hz   = tick;

endmodule
